// File: rtl/hd44780_byte_sequencer_if.sv
// Byte request handshake and LCD-side write signals of the HD44780 byte sequencer.
interface hd44780_byte_sequencer_if;
  logic       i_valid;
  logic       i_rs;
  logic [7:0] i_byte;
  logic       o_ready;
  logic       o_ena;
  logic       o_data;
  logic       o_e_trigger;
  logic [7:0] o_db;

  modport master (
    output i_valid, i_rs, i_byte,
    input  o_ready, o_ena, o_data, o_e_trigger, o_db
  );

  modport slave (
    input  i_valid, i_rs, i_byte,
    output o_ready, o_ena, o_data, o_e_trigger, o_db
  );
endinterface

// File: rtl/hd44780_byte_sequencer.sv
// Sequences one HD44780 byte write: setup, E strobe, hold, then execution wait.
// Define HD44780_FOUR_BIT_EN to write the byte as two nibbles on DB7..DB4.
module hd44780_byte_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int HOLD_CYC       = 12,
  parameter int SHORT_WAIT_CYC = 480,
  parameter int LONG_WAIT_CYC  = 19700
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  hd44780_byte_sequencer_if.slave    bus
);

`ifdef HD44780_FOUR_BIT_EN
  localparam bit FOUR_BIT = 1'b1;
`else
  localparam bit FOUR_BIT = 1'b0;
`endif

  localparam logic [14:0] SETUP_LD = 15'(SETUP_CYC);
  localparam logic [14:0] HOLD_LD  = 15'(HOLD_CYC);
  localparam logic [14:0] SHORT_LD = 15'(SHORT_WAIT_CYC);
  localparam logic [14:0] LONG_LD  = 15'(LONG_WAIT_CYC);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [14:0] cnt_reg, cnt_next;
  logic        rs_reg, rs_next;
  logic [7:0]  byte_reg, byte_next;
  logic        nib_reg, nib_next;
  logic        ready_reg, ready_next;
  logic        ena_reg, ena_next;
  logic        trig_reg, trig_next;
  logic        data_reg, data_next;
  logic [7:0]  db_reg, db_next;
  logic        long_wait;

  // Clear display and return home take far longer to execute than anything else.
  assign long_wait = !rs_reg && (byte_reg == 8'h01 || byte_reg == 8'h02 || byte_reg == 8'h03);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rs_next    = rs_reg;
    byte_next  = byte_reg;
    nib_next   = nib_reg;
    data_next  = data_reg;
    db_next    = db_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.i_valid && ready_reg) begin
          rs_next    = bus.i_rs;
          byte_next  = bus.i_byte;
          nib_next   = 1'b0;
          data_next  = bus.i_rs;
          db_next    = FOUR_BIT ? {bus.i_byte[7:4], 4'h0} : bus.i_byte;
          state_next = SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_reg <= 15'd1) begin
          state_next = STROBE;
          cnt_next   = 15'd0;
        end else begin
          cnt_next = cnt_reg - 15'd1;
        end
      end
      STROBE: begin
        state_next = HOLD;
        cnt_next   = HOLD_LD;
      end
      HOLD: begin
        if (cnt_reg <= 15'd1) begin
          if (FOUR_BIT && !nib_reg) begin
            nib_next   = 1'b1;
            db_next    = {byte_reg[3:0], 4'h0};
            state_next = SETUP;
            cnt_next   = SETUP_LD;
          end else begin
            state_next = WAIT;
            cnt_next   = long_wait ? LONG_LD : SHORT_LD;
          end
        end else begin
          cnt_next = cnt_reg - 15'd1;
        end
      end
      WAIT: begin
        if (cnt_reg <= 15'd1) begin
          state_next = IDLE;
          cnt_next   = 15'd0;
        end else begin
          cnt_next = cnt_reg - 15'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 15'd0;
      end
    endcase

    ready_next = (state_next == IDLE);
    ena_next   = (state_next != IDLE);
    trig_next  = (state_next == STROBE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 15'd0;
      rs_reg    <= 1'b0;
      byte_reg  <= 8'h00;
      nib_reg   <= 1'b0;
      ready_reg <= 1'b0;
      ena_reg   <= 1'b0;
      trig_reg  <= 1'b0;
      data_reg  <= 1'b0;
      db_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rs_reg    <= rs_next;
      byte_reg  <= byte_next;
      nib_reg   <= nib_next;
      ready_reg <= ready_next;
      ena_reg   <= ena_next;
      trig_reg  <= trig_next;
      data_reg  <= data_next;
      db_reg    <= db_next;
    end
  end

  assign bus.o_ready     = ready_reg;
  assign bus.o_ena       = ena_reg;
  assign bus.o_data      = data_reg;
  assign bus.o_e_trigger = trig_reg;
  assign bus.o_db        = db_reg;

endmodule

// File: tb/tb_hd44780_byte_sequencer.sv
// Bench for hd44780_byte_sequencer: offset-based timeline model checked every cycle plus directed literals.
module tb_hd44780_byte_sequencer;

`ifdef HD44780_FOUR_BIT_EN
  localparam bit FOUR = 1'b1;
`else
  localparam bit FOUR = 1'b0;
`endif
  localparam int S   = 2;
  localparam int H   = 12;
  localparam int SW  = 480;
  localparam int LW  = 19700;
  localparam int NPH = FOUR ? 2 : 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  hd44780_byte_sequencer_if bus ();

  hd44780_byte_sequencer #(
    .SETUP_CYC(S), .HOLD_CYC(H), .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: a transaction is a timeline of offsets from its acceptance edge.
  bit         m_busy  = 1'b0;
  bit         m_ready = 1'b0;
  int         m_t     = 0;
  bit         m_rs    = 1'b0;
  logic [7:0] m_byte  = 8'h00;

  function automatic int txn_len(input bit r, input logic [7:0] b);
    int w;
    w = (!r && b >= 8'h01 && b <= 8'h03) ? LW : SW;
    return NPH * (S + 1 + H) + w;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    chk_en <= 1'b1;
    if (rst) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_t <= 0; m_rs <= 1'b0; m_byte <= 8'h00;
    end else if (!m_busy && m_ready && bus.i_valid) begin
      m_busy <= 1'b1; m_ready <= 1'b0; m_t <= 0; m_rs <= bus.i_rs; m_byte <= bus.i_byte;
    end else if (m_busy) begin
      if (m_t + 1 >= txn_len(m_rs, m_byte)) begin
        m_busy <= 1'b0; m_ready <= 1'b1;
      end else begin
        m_t <= m_t + 1;
      end
    end else begin
      m_ready <= 1'b1;
    end
  end

  initial begin : compare
    bit         e_trig;
    logic [7:0] e_db;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_trig = m_busy && (m_t == S || (FOUR && m_t == 2 * S + 1 + H));
        if (!FOUR)                          e_db = m_byte;
        else if (m_busy && m_t < S + 1 + H) e_db = {m_byte[7:4], 4'h0};
        else                                e_db = {m_byte[3:0], 4'h0};
        total++;
        if (bus.o_ready !== m_ready || bus.o_ena !== m_busy || bus.o_e_trigger !== e_trig ||
            bus.o_data !== m_rs || bus.o_db !== e_db) begin
          bad++;
          $display("FAIL model cyc=%0d got rdy=%b ena=%b trg=%b dat=%b db=%h want rdy=%b ena=%b trg=%b dat=%b db=%h",
                   cyc, bus.o_ready, bus.o_ena, bus.o_e_trigger, bus.o_data, bus.o_db,
                   m_ready, m_busy, e_trig, m_rs, e_db);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 30000 && bus.o_ready !== 1'b1; k++) @(negedge clk);
  endtask

  task automatic run_byte(input bit r, input logic [7:0] b, input int exp_lat, input logic [7:0] exp_db0);
    int  e0, ntrig, first_t, last_t;
    bit  done;
    wait_ready();
    bus.i_valid = 1'b1; bus.i_rs = r; bus.i_byte = b;
    @(negedge clk);
    e0 = cyc;
    bus.i_valid = 1'b0;
    check($sformatf("db0_%h", b), bus.o_db, exp_db0);
    check($sformatf("data_%h", b), bus.o_data, r);
    ntrig = 0; first_t = -1; last_t = -1; done = 1'b0;
    for (int k = 0; k < 25000 && !done; k++) begin
      @(negedge clk);
      if (bus.o_e_trigger) begin
        ntrig++;
        if (first_t < 0) first_t = cyc - e0;
        last_t = cyc - e0;
      end
      if (bus.o_ready) done = 1'b1;
    end
    if (!done) $display("FAIL timeout_%h got=busy want=ready", b);
    check($sformatf("ntrig_%h", b), ntrig, NPH);
    check($sformatf("trig1_%h", b), first_t, 2);
    check($sformatf("trig2_%h", b), last_t, FOUR ? 17 : 2);
    check($sformatf("lat_%h_rs%0d", b, r), cyc - e0, exp_lat);
  endtask

  initial begin : main
    int e0, rdy, toff, n;
    int extra;
    logic [7:0] hi_a5, d41, d33, d55;
    extra = FOUR ? 15 : 0;
    hi_a5 = FOUR ? 8'hA0 : 8'hA5;
    d41   = FOUR ? 8'h40 : 8'h41;
    d33   = FOUR ? 8'h30 : 8'h33;
    d55   = FOUR ? 8'h50 : 8'h55;

    rst = 1'b1; bus.i_valid = 1'b0; bus.i_rs = 1'b0; bus.i_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.o_ready, 0);
    check("rst_ena", bus.o_ena, 0);
    check("rst_db", bus.o_db, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.o_ready, 1);

    run_byte(1'b1, 8'h41, 495 + extra, d41);
    run_byte(1'b0, 8'h01, 19715 + extra, FOUR ? 8'h00 : 8'h01);
    run_byte(1'b0, 8'h00, 495 + extra, 8'h00);
    run_byte(1'b0, 8'h03, 19715 + extra, FOUR ? 8'h00 : 8'h03);
    run_byte(1'b0, 8'h04, 495 + extra, FOUR ? 8'h00 : 8'h04);
    run_byte(1'b1, 8'h02, 495 + extra, FOUR ? 8'h00 : 8'h02);
    run_byte(1'b1, 8'hA5, 495 + extra, hi_a5);

    // Request held while busy; the new byte must not disturb the bus.
    wait_ready();
    bus.i_valid = 1'b1; bus.i_rs = 1'b1; bus.i_byte = 8'h33;
    @(negedge clk);
    repeat (10) @(negedge clk);
    bus.i_byte = 8'h55;
    wait_ready();
    rdy = cyc;
    check("held_db", bus.o_db, FOUR ? 8'h30 : 8'h33);
    @(negedge clk);
    check("b2b_ready", bus.o_ready, 0);
    check("b2b_db", bus.o_db, d55);
    toff = -1;
    for (int k = 0; k < 20 && toff < 0; k++) begin
      if (bus.o_e_trigger) toff = cyc - (rdy + 1);
      else @(negedge clk);
    end
    check("b2b_trig", toff, 2);
    bus.i_valid = 1'b0;
    if (d33 == 8'h00) $display("note d33 zero");

    // Reset during WAIT aborts the byte.
    wait_ready();
    bus.i_valid = 1'b1; bus.i_rs = 1'b1; bus.i_byte = 8'h77;
    @(negedge clk);
    e0 = cyc;
    bus.i_valid = 1'b0;
    while (cyc < e0 + 99) @(negedge clk);
    rst = 1'b1; bus.i_valid = 1'b1;
    @(negedge clk);
    check("abort_ena", bus.o_ena, 0);
    check("abort_ready", bus.o_ready, 0);
    check("abort_data", bus.o_data, 0);
    check("abort_db", bus.o_db, 8'h00);
    rst = 1'b0; bus.i_valid = 1'b0;
    @(negedge clk);
    check("abort_rdy_next", bus.o_ready, 1);
    n = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.o_e_trigger) n++;
    end
    check("abort_no_trig", n, 0);

    // Reset wins over a simultaneous request while idle.
    rst = 1'b1; bus.i_valid = 1'b1; bus.i_rs = 1'b0; bus.i_byte = 8'h01;
    @(negedge clk);
    rst = 1'b0;
    check("rst_prio_ena", bus.o_ena, 0);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_prio_idle", bus.o_ena, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hd44780_byte_sequencer.md
HD44780_BYTE_SEQUENCER -- requirements
Module: hd44780_byte_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, meaning the number of cycles o_db and o_data are stable before the strobe (allowed range 1..15).
REQ-002 SHALL have parameter HOLD_CYC, default 12, meaning the number of cycles after the strobe before the next phase (allowed range 10..255, which covers the downstream E pulse).
REQ-003 SHALL have parameter SHORT_WAIT_CYC, default 480, meaning the execution wait in cycles for ordinary bytes (about 40 us at 12 MHz; allowed range 1..32767).
REQ-004 SHALL have parameter LONG_WAIT_CYC, default 19700, meaning the execution wait in cycles for clear/home commands (about 1.64 ms; allowed range 1..32767).
REQ-005 SHALL have port i_clk, input, 1 bit: system clock.
REQ-006 SHALL have port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port i_valid, input, 1 bit: upstream byte request.
REQ-008 SHALL have port i_rs, input, 1 bit: register select (0 = command, 1 = data).
REQ-009 SHALL have port i_byte, input, 8 bits: byte to write.
REQ-010 SHALL have port o_ready, output, 1 bit: sequencer idle and able to accept a byte.
REQ-011 SHALL have port o_ena, output, 1 bit: transaction active; feeds the downstream write stage's enable.
REQ-012 SHALL have port o_data, output, 1 bit: captured RS; feeds the downstream write stage's data input.
REQ-013 SHALL have port o_e_trigger, output, 1 bit: single-cycle strobe that launches the downstream E pulse.
REQ-014 SHALL have port o_db, output, 8 bits: LCD data bus DB7..DB0.

Function
REQ-015 SHALL use a state machine with states IDLE, SETUP, STROBE, HOLD and WAIT, all outputs registered.
REQ-016 SHALL drive o_ready=1 only in IDLE, and SHALL accept a byte on an edge where i_valid&o_ready=1, capturing i_rs and i_byte.
REQ-017 SHALL ignore i_valid while o_ready=0; there is no buffering, so upstream holds the request.
REQ-018 SHALL, on acceptance edge E0, go to SETUP, drive o_db and o_data from the captured values, and hold them stable until the return to IDLE.
REQ-019 SHALL leave SETUP after SETUP_CYC cycles, then spend exactly one cycle in STROBE with o_e_trigger=1 (the strobe is high after edge E0+SETUP_CYC).
REQ-020 SHALL drive o_ena=1 in every non-IDLE state and 0 in IDLE; o_e_trigger SHALL be 0 outside STROBE.
REQ-021 SHALL remain in HOLD for HOLD_CYC cycles, then in WAIT for the selected wait count, then return to IDLE.
REQ-022 SHALL select LONG_WAIT_CYC when the captured rs=0 and the captured byte is 8'h01, 8'h02 or 8'h03; all other values, including rs=0 with 8'h00, SHALL use SHORT_WAIT_CYC.
REQ-023 SHALL reassert o_ready after edge E0+SETUP_CYC+1+HOLD_CYC+wait; with defaults this is E0+495 (short wait) or E0+19715 (long wait).
REQ-024 SHALL implement the phase and wait counters as at least 15 bits, loaded on state entry and counting down to 1, with no wrap-around.
REQ-025 SHALL allow a new acceptance on the same edge o_ready is first seen high, giving back-to-back bytes with no extra idle cycle.

Reset
REQ-026 SHALL, while i_reset=1, force IDLE and set o_ready=0, o_ena=0, o_e_trigger=0, o_data=0, o_db=8'h00 and all counters to 0.
REQ-027 SHALL drive o_ready=1 in the first cycle after i_reset falls.
REQ-028 SHALL abort a transaction on reset in any state, discarding it with no strobe afterwards; i_reset SHALL take priority over a simultaneous i_valid.

Configuration
REQ-029 SHALL provide macro HD44780_FOUR_BIT_EN to select the LCD bus mode.
REQ-030 SHALL, when HD44780_FOUR_BIT_EN is undefined, operate in 8-bit mode with one strobe per byte and o_db = the byte.
REQ-031 SHALL, when HD44780_FOUR_BIT_EN is defined, sequence as: o_db = {byte[7:4],4'h0}, then SETUP, STROBE and HOLD, then o_db = {byte[3:0],4'h0}, then SETUP, STROBE, HOLD and WAIT, giving two strobes and one wait.
REQ-032 SHALL, in four-bit mode, place the second strobe after edge E0+2*SETUP_CYC+1+HOLD_CYC (E0+17 with defaults) and reassert o_ready after edge E0+2*(SETUP_CYC+1+HOLD_CYC)+wait (E0+510 short wait).

Verification
REQ-033 SHALL verify that reset, then i_valid=1, i_rs=1, i_byte=8'h41 on edge E0, gives o_db=8'h41 and o_data=1 from E0, o_e_trigger high for exactly one cycle after E0+2, and o_ready=1 after E0+495.
REQ-034 SHALL verify that i_rs=0, i_byte=8'h01 gives o_ready low until E0+19715, and that i_rs=0, i_byte=8'h00 gives o_ready at E0+495.
REQ-035 SHALL verify that i_valid held high with i_byte changed to 8'h55 while busy leaves o_db at its original value, and that 8'h55 is accepted on the ready edge with the next strobe after that edge+2.
REQ-036 SHALL verify that i_reset pulsed for one cycle at E0+100 (during WAIT) drives all outputs to reset values, o_ready=1 the next cycle, and no further o_e_trigger.
REQ-037 SHALL verify that, with HD44780_FOUR_BIT_EN defined and i_byte=8'hA5 at E0, o_db=8'hA0 with a strobe after E0+2, o_db=8'h50 with a strobe after E0+17, and o_ready after E0+510.
